seq_divider_32by16: RTL and testbench

//   Iterative restoring divider, the inverse of dadda_16x16_uncompressed3: 2*W-bit dividend / W-bit divisor.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 21 ++
 rtl/seq_divider_32by16.sv | 111 +++++++++++
 tb/tb_seq_divider_32by16.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and widths for the sequential 2W/W restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_W = 16;
    localparam int CNT_W = $clog2(DIV_W);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module div_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] rem,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0]   r_ext;
    logic [W-1:0] diff_lo;

    assign r_ext   = {rem, bit_in};
    // The true difference always fits in W bits when it is taken, so modular W-bit subtraction suffices.
    assign diff_lo = r_ext[W-1:0] - divisor;
    assign q_bit   = (r_ext >= {1'b0, divisor});
    assign rem_out = q_bit ? diff_lo : r_ext[W-1:0];

endmodule

// File: rtl/seq_divider_32by16.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional build macro DIV_FAST_EXIT_EN: exception ops skip the CALC phase.
module seq_divider_32by16
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [W-1:0]    rem_reg;
    logic [W-1:0]    lo_reg;
    logic [W-1:0]    dvs_reg;
    logic [W-1:0]    quot_reg;
    logic            exc_reg;
    logic            dz_reg;
    logic            ov_reg;

    logic [W-1:0]    step_rem;
    logic            step_q;
    logic [W-1:0]    in_hi;
    logic            in_dz;
    logic            in_ov;

    assign in_hi = dividend[2*W-1:W];
    assign in_dz = (divisor == '0);
    assign in_ov = !in_dz && (in_hi >= divisor);

    div_step #(.W(W)) u_step (
        .rem     (rem_reg),
        .bit_in  (lo_reg[W-1]),
        .divisor (dvs_reg),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign quotient    = quot_reg;
    assign remainder   = rem_reg;
    assign div_by_zero = dz_reg;
    assign overflow    = ov_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rem_reg   <= '0;
            lo_reg    <= '0;
            dvs_reg   <= '0;
            quot_reg  <= '0;
            exc_reg   <= 1'b0;
            dz_reg    <= 1'b0;
            ov_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        dvs_reg  <= divisor;
                        rem_reg  <= in_hi;
                        lo_reg   <= dividend[W-1:0];
                        cnt_reg  <= CW'(W - 1);
                        dz_reg   <= in_dz;
                        ov_reg   <= in_ov;
                        exc_reg  <= in_dz || in_ov;
                        quot_reg <= (in_dz || in_ov) ? '1 : '0;
`ifdef DIV_FAST_EXIT_EN
                        state_reg <= (in_dz || in_ov) ? DONE : CALC;
`else
                        state_reg <= CALC;
`endif
                    end
                end
                CALC: begin
                    // Exception results were forced at accept; the step only runs for legal ops.
                    if (!exc_reg) begin
                        rem_reg  <= step_rem;
                        quot_reg <= {quot_reg[W-2:0], step_q};
                    end
                    lo_reg  <= {lo_reg[W-2:0], 1'b0};
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_32by16.sv
// Self-checking bench for seq_divider_32by16: directed vectors, back-pressure, mid-op reset, random ops.
module tb_seq_divider_32by16;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   dividend;
    logic [15:0]   divisor;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   quotient;
    logic [15:0]   remainder;
    logic          div_by_zero;
    logic          overflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_divider_32by16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division plus the exception rules.
    function automatic void model(input logic [31:0] dvd, input logic [15:0] dvs,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dz, output logic ov);
        logic [31:0] qq, rr, d32;
        dz = (dvs == 16'd0);
        ov = !dz && (dvd[31:16] >= dvs);
        if (dz || ov) begin
            q = 16'hFFFF;
            r = dvd[31:16];
        end else begin
            d32 = {16'd0, dvs};
            qq  = dvd / d32;
            rr  = dvd % d32;
            q   = qq[15:0];
            r   = rr[15:0];
        end
    endfunction

    task automatic check_model_vs_const(input vec_t v);
        logic [15:0] q, r;
        logic dz, ov;
        model(v.dvd, v.dvs, q, r, dz, ov);
        chk("model_table_q", {16'd0, q}, {16'd0, v.q});
        chk("model_table_r", {16'd0, r}, {16'd0, v.r});
    endtask

    // Runs one operation starting at a negedge; returns at a negedge after the output handshake.
    task automatic run_op(input logic [31:0] dvd, input logic [15:0] dvs, input int stall);
        logic [15:0] eq, er;
        logic edz, eov;
        int lat, exp_lat, guard;
        model(dvd, dvs, eq, er, edz, eov);
        exp_lat = W + 1;
`ifdef DIV_FAST_EXIT_EN
        if (edz || eov) exp_lat = 1;
`endif
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_before_op", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("quotient", {16'd0, quotient}, {16'd0, eq});
        chk("remainder", {16'd0, remainder}, {16'd0, er});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, edz});
        chk("overflow", {31'd0, overflow}, {31'd0, eov});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_q", {16'd0, quotient}, {16'd0, eq});
            chk("hold_r", {16'd0, remainder}, {16'd0, er});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("after_hs_valid", {31'd0, out_valid}, 32'd0);
        chk("after_hs_ready", {31'd0, in_ready}, 32'd1);
        $display("op %h / %h -> q=%h r=%h dz=%0d ov=%0d lat=%0d (exp q=%h r=%h dz=%0d ov=%0d lat=%0d) stall=%0d",
                 dvd, dvs, quotient, remainder, div_by_zero, overflow, lat,
                 eq, er, edz, eov, exp_lat, stall);
    endtask

    initial begin
        vecs[0] = '{32'hAAA95556, 16'hAAAA, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{32'h0000A957, 16'h00AA, 16'h00FF, 16'h0001, 1'b0, 1'b0};
        vecs[2] = '{32'h0000FE01, 16'h00FF, 16'h00FF, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{32'h12345678, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0};
        vecs[4] = '{32'h00010000, 16'h0001, 16'hFFFF, 16'h0001, 1'b0, 1'b1};
        vecs[5] = '{32'h0000FFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_q", {16'd0, quotient}, 32'd0);
        chk("reset_r", {16'd0, remainder}, 32'd0);
        chk("reset_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors: table constants cross-checked against the model, then run.
        for (int i = 0; i < 6; i++) begin
            check_model_vs_const(vecs[i]);
            run_op(vecs[i].dvd, vecs[i].dvs, 0);
        end

        // Back-pressure: hold DONE for 10 cycles.
        run_op(32'hAAA95556, 16'hAAAA, 10);

        // Reset during CALC, then a fresh op.
        in_valid = 1'b1;
        dividend = 32'hAAA95556;
        divisor  = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midreset_q", {16'd0, quotient}, 32'd0);
        chk("midreset_r", {16'd0, remainder}, 32'd0);
        $display("reset asserted mid-CALC: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32'h00000064, 16'h0007, 0);

        // Randomized ops against the model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] dvd;
            logic [15:0] dvs, qv, rv;
            int mode;
            mode = $urandom_range(0, 4);
            dvs  = 16'($urandom);
            if (mode == 0) begin
                dvd = $urandom;
            end else if (mode == 4) begin
                dvs = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 3));
                dvd = $urandom;
            end else begin
                if (dvs == 16'd0) dvs = 16'd1;
                qv  = 16'($urandom);
                rv  = 16'($urandom_range(0, 32'(dvs) - 1));
                dvd = {16'd0, qv} * {16'd0, dvs} + {16'd0, rv};
            end
            run_op(dvd, dvs, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
